// File: rtl/dest_ip_tbl_ctrl.sv
// Initiator side of the destination-IP filter table access interface.
// Sequences single-cycle register commands into table requests, waits for acks with a timeout, and offers a clear-all sweep.
module dest_ip_tbl_ctrl #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int TBL_DEPTH          = 32,
  parameter int ACK_TIMEOUT        = 16
) (
  input  logic                          AXI_ACLK,
  input  logic                          reset,
  input  logic                          cmd_valid,
  input  logic                          cmd_write,
  input  logic                          cmd_clear,
  input  logic [TBL_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          cmd_ready,
  output logic                          cmd_overrun,
  output logic                          rsp_valid,
  output logic                          rsp_error,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [31:0]                   timeout_count,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic                          tbl_wr_ack,
  output logic                          tbl_rd_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  // The wait gives up on the edge where the timer would reach ACK_TIMEOUT-1,
  // so the error response lands exactly ACK_TIMEOUT cycles after the request.
  localparam logic [TW-1:0]             TMR_LAST   = TW'(ACK_TIMEOUT - 2);
  localparam logic [TBL_ADDR_WIDTH-1:0] SWEEP_LAST = TBL_ADDR_WIDTH'(TBL_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    CLR_REQ,
    CLR_WAIT
  } state_t;

  state_t                          state_q;
  logic [TW-1:0]                   timer_q, timer_d;
  logic [TBL_ADDR_WIDTH-1:0]       sweep_q, sweep_d;
  logic [31:0]                     tout_cnt_q, tout_cnt_d;
  logic                            ready_q;
  logic                            rsp_valid_q;
  logic                            rsp_error_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q;
  logic                            wr_req_q;
  logic [TBL_ADDR_WIDTH-1:0]       wr_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data_q;
  logic                            rd_req_q;
  logic [TBL_ADDR_WIDTH-1:0]       rd_addr_q;
  logic                            ack_hit;
  logic                            expired;

  always_comb begin
    timer_d    = timer_q + 1'b1;
    sweep_d    = sweep_q + 1'b1;
    tout_cnt_d = (&tout_cnt_q) ? tout_cnt_q : tout_cnt_q + 32'd1;
    ack_hit    = (state_q == RD_WAIT) ? tbl_rd_ack : tbl_wr_ack;
    expired    = (timer_q == TMR_LAST);
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      sweep_q     <= '0;
      tout_cnt_q  <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
      wr_req_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            ready_q <= 1'b0;
            timer_q <= '0;
            if (cmd_clear) begin
              state_q   <= CLR_REQ;
              sweep_q   <= '0;
              wr_req_q  <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= '0;
            end else if (cmd_write) begin
              state_q   <= WR_REQ;
              wr_req_q  <= 1'b1;
              wr_addr_q <= cmd_addr;
              wr_data_q <= cmd_wdata;
            end else begin
              state_q   <= RD_REQ;
              rd_req_q  <= 1'b1;
              rd_addr_q <= cmd_addr;
            end
          end
        end
        WR_REQ: begin
          state_q <= WR_WAIT;
          timer_q <= '0;
        end
        RD_REQ: begin
          state_q <= RD_WAIT;
          timer_q <= '0;
        end
        CLR_REQ: begin
          state_q <= CLR_WAIT;
          timer_q <= '0;
        end
        WR_WAIT, RD_WAIT, CLR_WAIT: begin
          if (ack_hit) begin
            if (state_q == RD_WAIT) begin
              rdata_q <= tbl_rd_data;
            end
            if ((state_q == CLR_WAIT) && (sweep_q != SWEEP_LAST)) begin
              state_q   <= CLR_REQ;
              sweep_q   <= sweep_d;
              wr_req_q  <= 1'b1;
              wr_addr_q <= sweep_d;
              wr_data_q <= '0;
            end else begin
              state_q     <= IDLE;
              ready_q     <= 1'b1;
              rsp_valid_q <= 1'b1;
            end
          end else if (expired) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            tout_cnt_q  <= tout_cnt_d;
          end else begin
            timer_q <= timer_d;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign cmd_overrun   = cmd_valid & ~ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_rdata     = rdata_q;
  assign timeout_count = tout_cnt_q;
  assign tbl_wr_req    = wr_req_q;
  assign tbl_wr_addr   = wr_addr_q;
  assign tbl_wr_data   = wr_data_q;
  assign tbl_rd_req    = rd_req_q;
  assign tbl_rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_dest_ip_tbl_ctrl.sv
// Directed bench for dest_ip_tbl_ctrl: table responder model plus request/response scoreboard.
module tb_dest_ip_tbl_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int TO    = 16;

  logic          AXI_ACLK = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic          cmd_clear = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready;
  logic          cmd_overrun;
  logic          rsp_valid;
  logic          rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic [31:0]   timeout_count;
  logic          tbl_wr_req;
  logic [AW-1:0] tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic          tbl_wr_ack = 1'b0;
  logic          tbl_rd_req;
  logic [AW-1:0] tbl_rd_addr;
  logic [DW-1:0] tbl_rd_data = '0;
  logic          tbl_rd_ack = 1'b0;

  always #5 AXI_ACLK = ~AXI_ACLK;

  dest_ip_tbl_ctrl #(
    .C_S_AXI_DATA_WIDTH(DW),
    .TBL_ADDR_WIDTH    (AW),
    .TBL_DEPTH         (DEPTH),
    .ACK_TIMEOUT       (TO)
  ) dut (
    .AXI_ACLK     (AXI_ACLK),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_write    (cmd_write),
    .cmd_clear    (cmd_clear),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_ready    (cmd_ready),
    .cmd_overrun  (cmd_overrun),
    .rsp_valid    (rsp_valid),
    .rsp_error    (rsp_error),
    .rsp_rdata    (rsp_rdata),
    .timeout_count(timeout_count),
    .tbl_wr_req   (tbl_wr_req),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
    .tbl_wr_ack   (tbl_wr_ack),
    .tbl_rd_req   (tbl_rd_req),
    .tbl_rd_addr  (tbl_rd_addr),
    .tbl_rd_data  (tbl_rd_data),
    .tbl_rd_ack   (tbl_rd_ack)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge AXI_ACLK) cyc <= cyc + 1;

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    bit            err;
    logic [DW-1:0] rdata;
    int            at;
  } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder: acks ack_dly cycles after seeing a request when ack_en is set.
  logic [DW-1:0] mem [DEPTH];
  bit            ack_en    = 1'b1;
  int            ack_dly   = 1;
  bit            inject_rd = 1'b0;
  bit            pend      = 1'b0;
  bit            pend_wr   = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_data = '0;
  int            pend_cnt  = 0;

  always @(posedge AXI_ACLK) begin
    #1;
    tbl_wr_ack = 1'b0;
    tbl_rd_ack = inject_rd;
    if (pend) begin
      if (pend_cnt <= 1) begin
        pend = 1'b0;
        if (pend_wr) begin
          tbl_wr_ack     = 1'b1;
          mem[pend_addr] = pend_data;
        end else begin
          tbl_rd_ack  = 1'b1;
          tbl_rd_data = mem[pend_addr];
        end
      end else begin
        pend_cnt--;
      end
    end
  end

  req_t er;
  rsp_t es;

  always @(negedge AXI_ACLK) begin
    if (!reset) begin
      if (tbl_wr_req || tbl_rd_req) begin
        chk("req_exclusive", 64'(tbl_wr_req && tbl_rd_req), 64'd0);
        pend      = ack_en;
        pend_wr   = tbl_wr_req;
        pend_addr = tbl_wr_req ? tbl_wr_addr : tbl_rd_addr;
        pend_data = tbl_wr_data;
        pend_cnt  = ack_dly;
        if (exp_req_q.size() == 0) begin
          chk("req_unexpected", 64'd1, 64'd0);
        end else begin
          er = exp_req_q.pop_front();
          chk("req_type", 64'(tbl_wr_req), 64'(er.wr));
          chk("req_addr", 64'(pend_addr), 64'(er.addr));
          if (er.wr) chk("req_data", 64'(tbl_wr_data), 64'(er.data));
        end
      end
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          es = exp_rsp_q.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(es.at));
          chk("rsp_error", 64'(rsp_error), 64'(es.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(es.rdata));
        end
      end
    end
  end

  // Returns the cycle index of "cycle 1" (the one right after the sampling edge).
  task automatic issue(input bit wr, input bit clr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output int base);
    int n;
    n = 0;
    @(negedge AXI_ACLK);
    while (!cmd_ready && n < 200) begin
      @(negedge AXI_ACLK);
      n++;
    end
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    @(posedge AXI_ACLK);
    #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_clear = clr;
    cmd_addr  = a;
    cmd_wdata = d;
    @(posedge AXI_ACLK);
    #1;
    base      = cyc;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
  endtask

  task automatic push_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.data = d;
    exp_req_q.push_back(r);
  endtask

  task automatic push_rsp(input bit err, input logic [DW-1:0] rd, input int at);
    rsp_t r;
    r.err = err; r.rdata = rd; r.at = at;
    exp_rsp_q.push_back(r);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_rsp_q.size() != 0 && n < 300) begin
      @(negedge AXI_ACLK);
      n++;
    end
    chk(tag, 64'(exp_rsp_q.size()), 64'd0);
    repeat (2) @(negedge AXI_ACLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] exp_rdata;
  int            base;

  initial begin
    foreach (mem[i]) mem[i] = '0;
    exp_rdata = '0;
    repeat (3) @(posedge AXI_ACLK);
    #1 reset = 1'b0;
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_overrun", 64'(cmd_overrun), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_error", 64'(rsp_error), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_timeout_count", 64'(timeout_count), 64'd0);
    chk("rst_wr_req", 64'(tbl_wr_req), 64'd0);
    chk("rst_rd_req", 64'(tbl_rd_req), 64'd0);
    chk("rst_wr_addr", 64'(tbl_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(tbl_wr_data), 64'd0);
    chk("rst_rd_addr", 64'(tbl_rd_addr), 64'd0);

    // Write, then read back, then write again leaving rsp_rdata untouched.
    issue(1'b1, 1'b0, 5'd5, 32'h0A000001, base);
    push_req(1'b1, 5'd5, 32'h0A000001);
    push_rsp(1'b0, exp_rdata, base + 2);
    drain("wr5_done");

    issue(1'b0, 1'b0, 5'd5, '0, base);
    push_req(1'b0, 5'd5, '0);
    exp_rdata = 32'h0A000001;
    push_rsp(1'b0, exp_rdata, base + 2);
    drain("rd5_done");

    issue(1'b1, 1'b0, 5'd6, 32'h12345678, base);
    push_req(1'b1, 5'd6, 32'h12345678);
    push_rsp(1'b0, exp_rdata, base + 2);
    drain("wr6_done");

    // Read never acked: error exactly ACK_TIMEOUT cycles after the request; late ack ignored.
    ack_en = 1'b0;
    issue(1'b0, 1'b0, 5'd5, '0, base);
    push_req(1'b0, 5'd5, '0);
    push_rsp(1'b1, exp_rdata, base + TO);
    drain("rd_timeout_done");
    chk("timeout_count_1", 64'(timeout_count), 64'd1);
    repeat (20) @(negedge AXI_ACLK);
    inject_rd = 1'b1;
    @(negedge AXI_ACLK);
    inject_rd = 1'b0;
    repeat (5) @(negedge AXI_ACLK);
    chk("late_ack_ready", 64'(cmd_ready), 64'd1);
    ack_en = 1'b1;

    // Ack on the last cycle of the window succeeds; one cycle later is a timeout.
    ack_dly = TO - 1;
    issue(1'b0, 1'b0, 5'd6, '0, base);
    push_req(1'b0, 5'd6, '0);
    exp_rdata = 32'h12345678;
    push_rsp(1'b0, exp_rdata, base + TO);
    drain("rd_last_window_done");
    chk("timeout_count_still_1", 64'(timeout_count), 64'd1);

    ack_dly = TO;
    issue(1'b0, 1'b0, 5'd5, '0, base);
    push_req(1'b0, 5'd5, '0);
    push_rsp(1'b1, exp_rdata, base + TO);
    drain("rd_just_late_done");
    repeat (3) @(negedge AXI_ACLK);
    chk("timeout_count_2", 64'(timeout_count), 64'd2);
    ack_dly = 1;

    // Clear-all sweep with an overrun attempt mid-sweep.
    issue(1'b0, 1'b1, 5'd9, 32'hFFFFFFFF, base);
    for (int i = 0; i < DEPTH; i++) push_req(1'b1, AW'(i), '0);
    push_rsp(1'b0, exp_rdata, base + 2 * DEPTH);
    repeat (10) @(posedge AXI_ACLK);
    #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 5'd3;
    cmd_wdata = 32'hDEADBEEF;
    #2;
    chk("overrun_pulse", 64'(cmd_overrun), 64'd1);
    chk("busy_not_ready", 64'(cmd_ready), 64'd0);
    @(posedge AXI_ACLK);
    #1 cmd_valid = 1'b0;
    #1;
    chk("overrun_cleared", 64'(cmd_overrun), 64'd0);
    drain("clear_done");

    issue(1'b0, 1'b0, 5'd5, '0, base);
    push_req(1'b0, 5'd5, '0);
    exp_rdata = '0;
    push_rsp(1'b0, exp_rdata, base + 2);
    drain("rd_after_clear_done");

    // Wrong-type ack during WR_WAIT must not complete the write.
    ack_en = 1'b0;
    issue(1'b1, 1'b0, 5'd7, 32'h0000BEEF, base);
    push_req(1'b1, 5'd7, 32'h0000BEEF);
    push_rsp(1'b1, exp_rdata, base + TO);
    @(negedge AXI_ACLK);
    inject_rd = 1'b1;
    @(negedge AXI_ACLK);
    inject_rd = 1'b0;
    drain("wr_wrong_ack_done");
    chk("timeout_count_3", 64'(timeout_count), 64'd3);

    // Reset while waiting for a read ack.
    issue(1'b0, 1'b0, 5'd9, '0, base);
    push_req(1'b0, 5'd9, '0);
    repeat (3) @(posedge AXI_ACLK);
    #1 reset = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rst_rd_req", 64'(tbl_rd_req), 64'd0);
    chk("mid_rst_wr_req", 64'(tbl_wr_req), 64'd0);
    chk("mid_rst_rd_addr", 64'(tbl_rd_addr), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_timeout_count", 64'(timeout_count), 64'd0);
    reset  = 1'b0;
    ack_en = 1'b1;
    repeat (25) @(negedge AXI_ACLK);
    chk("final_req_queue", 64'(exp_req_q.size()), 64'd0);
    chk("final_rsp_queue", 64'(exp_rsp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
